// File: rtl/ir_sensor_scan_if.sv
// Signal bundle between the IR scan engine (slave side) and the A2D / heading-fusion side (master).
interface ir_sensor_scan_if;
  logic        en;
  logic        MISO;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        IR_en;
  logic [11:0] lft_IR;
  logic [11:0] rght_IR;
  logic        lft_opn;
  logic        rght_opn;
  logic        IR_vld;

  modport master (
    output en, MISO,
    input  SS_n, SCLK, MOSI, IR_en, lft_IR, rght_IR, lft_opn, rght_opn, IR_vld
  );

  modport slave (
    input  en, MISO,
    output SS_n, SCLK, MOSI, IR_en, lft_IR, rght_IR, lft_opn, rght_opn, IR_vld
  );
endinterface

// File: rtl/ir_sensor_scan.sv
// Periodic IR wall scan: gates the emitters, reads left/right channels over SPI from the A2D
// and publishes a coherent sample pair with hysteretic open flags once per scan.
module ir_sensor_scan #(
  parameter int unsigned PERIOD     = 4096,
  parameter int unsigned EN_SETTLE  = 256,
  parameter int unsigned SCLK_DIV   = 32,
  parameter logic [2:0]  LFT_CH     = 3'd1,
  parameter logic [2:0]  RGHT_CH    = 3'd0,
  parameter logic [11:0] OPN_THRESH = 12'h400,
  parameter logic [11:0] OPN_HYST   = 12'h080
) (
  input  logic              clk,
  input  logic              rst,
  ir_sensor_scan_if.slave   bus
);

  localparam int unsigned PER_W     = $clog2(PERIOD);
  localparam int unsigned SET_W     = $clog2(EN_SETTLE);
  localparam int unsigned DIV_W     = $clog2(SCLK_DIV);
  localparam int unsigned HALF      = SCLK_DIV / 2;
  localparam int unsigned SLOT_W    = 6;
  // Half-period slots per frame: 0 front porch, 1..32 SCLK low/high, 33 inter-frame gap.
  localparam int unsigned LAST_SLOT = 33;

  typedef enum logic [2:0] {IDLE, SETTLE, CMD_L, DAT_L, CMD_R, DAT_R, DONE} state_t;

  state_t            state_q, state_d;
  logic [PER_W-1:0]  idle_q, idle_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic [DIV_W-1:0]  half_q, half_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [15:0]       shift_q, shift_d;
  logic [11:0]       lsmp_q, lsmp_d;

  logic        ss_n_q, ss_n_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        ir_en_q, ir_en_d;
  logic [11:0] lft_q, lft_d;
  logic [11:0] rght_q, rght_d;
  logic        lopn_q, lopn_d;
  logic        ropn_q, ropn_d;
  logic        vld_q, vld_d;

  logic        in_frame;
  logic        ss_low;
  logic        rise;
  logic        fall;
  logic [2:0]  ch;
  logic [15:0] word;

  function automatic logic opn_next(input logic cur, input logic [11:0] smp);
    if ({1'b0, smp} < {1'b0, OPN_THRESH}) return 1'b1;
    if ({1'b0, smp} > ({1'b0, OPN_THRESH} + {1'b0, OPN_HYST})) return 1'b0;
    return cur;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idle_q   <= '0;
      settle_q <= '0;
      half_q   <= '0;
      slot_q   <= '0;
      shift_q  <= '0;
      lsmp_q   <= '0;
      ss_n_q   <= 1'b1;
      sclk_q   <= 1'b1;
      mosi_q   <= 1'b0;
      ir_en_q  <= 1'b0;
      lft_q    <= '0;
      rght_q   <= '0;
      lopn_q   <= 1'b0;
      ropn_q   <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idle_q   <= idle_d;
      settle_q <= settle_d;
      half_q   <= half_d;
      slot_q   <= slot_d;
      shift_q  <= shift_d;
      lsmp_q   <= lsmp_d;
      ss_n_q   <= ss_n_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      ir_en_q  <= ir_en_d;
      lft_q    <= lft_d;
      rght_q   <= rght_d;
      lopn_q   <= lopn_d;
      ropn_q   <= ropn_d;
      vld_q    <= vld_d;
    end
  end

  // Next state, then outputs derived from the next state so registers line up with it.
  always_comb begin
    state_d  = state_q;
    idle_d   = idle_q;
    settle_d = settle_q;
    half_d   = half_q;
    slot_d   = slot_q;
    shift_d  = shift_q;
    lsmp_d   = lsmp_q;
    mosi_d   = mosi_q;
    lft_d    = lft_q;
    rght_d   = rght_q;
    lopn_d   = lopn_q;
    ropn_d   = ropn_q;
    vld_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!bus.en) begin
          idle_d = '0;
        end else if (idle_q == PER_W'(PERIOD - 1)) begin
          idle_d  = '0;
          state_d = SETTLE;
        end else begin
          idle_d = idle_q + PER_W'(1);
        end
      end
      SETTLE: begin
        if (settle_q == SET_W'(EN_SETTLE - 1)) begin
          settle_d = '0;
          state_d  = CMD_L;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      CMD_L, DAT_L, CMD_R, DAT_R: begin
        if (half_q == DIV_W'(HALF - 1)) begin
          half_d = '0;
          if (slot_q == SLOT_W'(LAST_SLOT)) begin
            slot_d = '0;
            case (state_q)
              CMD_L:   state_d = DAT_L;
              DAT_L:   state_d = CMD_R;
              CMD_R:   state_d = DAT_R;
              default: state_d = DONE;
            endcase
          end else begin
            slot_d = slot_q + SLOT_W'(1);
          end
        end else begin
          half_d = half_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    in_frame = (state_d == CMD_L) || (state_d == DAT_L) ||
               (state_d == CMD_R) || (state_d == DAT_R);
    ss_low   = in_frame && (slot_d < SLOT_W'(LAST_SLOT));
    rise     = ss_low && !slot_d[0] && (slot_d != '0) && (half_d == '0);
    fall     = ss_low && slot_d[0] && (half_d == '0);
    ch       = ((state_d == CMD_L) || (state_d == DAT_L)) ? LFT_CH : RGHT_CH;
    word     = {2'b00, ch, 11'h000};

    ss_n_d  = !ss_low;
    sclk_d  = !ss_low || !slot_d[0];
    ir_en_d = (state_d == SETTLE) || in_frame;

    if (!ss_low) mosi_d = 1'b0;
    else if (fall) mosi_d = word[4'd15 - slot_d[4:1]];

    if (rise && ((state_d == DAT_L) || (state_d == DAT_R))) shift_d = {shift_q[14:0], bus.MISO};

    if ((state_q == DAT_L) && (state_d == CMD_R)) lsmp_d = shift_q[11:0];

    // Publish both channels together so consumers never see a mixed pair.
    if (state_d == DONE) begin
      lft_d  = lsmp_q;
      rght_d = shift_q[11:0];
      lopn_d = opn_next(lopn_q, lsmp_q);
      ropn_d = opn_next(ropn_q, shift_q[11:0]);
      vld_d  = 1'b1;
    end
  end

  assign bus.SS_n     = ss_n_q;
  assign bus.SCLK     = sclk_q;
  assign bus.MOSI     = mosi_q;
  assign bus.IR_en    = ir_en_q;
  assign bus.lft_IR   = lft_q;
  assign bus.rght_IR  = rght_q;
  assign bus.lft_opn  = lopn_q;
  assign bus.rght_opn = ropn_q;
  assign bus.IR_vld   = vld_q;

endmodule

// File: tb/tb_ir_sensor_scan.sv
// Bench for ir_sensor_scan: SPI A2D model, bus monitors and a reference for samples/open flags.
module tb_ir_sensor_scan;
  localparam int unsigned PERIOD    = 1024;
  localparam int unsigned EN_SETTLE = 256;
  localparam int unsigned SCLK_DIV  = 32;
  localparam int unsigned SCAN_LEN  = PERIOD + EN_SETTLE + 4 * 34 * (SCLK_DIV / 2) + 1;

  logic clk = 1'b0;
  logic rst;

  ir_sensor_scan_if bus ();

  ir_sensor_scan #(.PERIOD(PERIOD), .EN_SETTLE(EN_SETTLE), .SCLK_DIV(SCLK_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // A2D model: answers each frame with the conversion of the channel addressed in the previous frame.
  logic [11:0] a2d_val [8];
  logic [3:0]  a2d_top = 4'h0;
  logic [2:0]  a2d_prev_ch = 3'd0;
  logic [15:0] a2d_tx = 16'h0;
  logic [15:0] a2d_rx = 16'h0;
  int          a2d_idx = 15;
  logic [15:0] mosi_log[$];

  always @(negedge bus.SCLK or negedge bus.SS_n) begin
    if (bus.SCLK === 1'b1) begin
      a2d_tx  = {a2d_top, a2d_val[a2d_prev_ch]};
      a2d_idx = 15;
    end else if (bus.SS_n === 1'b0 && a2d_idx >= 0) begin
      bus.MISO = a2d_tx[a2d_idx];
      a2d_idx--;
    end
  end

  always @(posedge bus.SCLK) if (bus.SS_n === 1'b0) a2d_rx = {a2d_rx[14:0], bus.MOSI};

  always @(posedge bus.SS_n) begin
    mosi_log.push_back(a2d_rx);
    a2d_prev_ch = a2d_rx[13:11];
  end

  // Bus monitors, sampled on the falling clock edge.
  int   cyc = 0;
  int   vld_cnt = 0, ss_falls = 0, ir_en_hi = 0, rises = 0, last_rise = 0;
  int   per_bad = 0, per_n = 0, en_rise = 0;
  bit   gap_pend = 1'b0;
  int   vld_t[$];
  int   rise_q[$];
  int   gap_q[$];
  logic prev_ss = 1'b1, prev_sclk = 1'b1, prev_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.IR_vld === 1'b1) begin
      vld_cnt++;
      vld_t.push_back(cyc);
    end
    if (bus.IR_en === 1'b1) ir_en_hi++;
    if (bus.IR_en === 1'b1 && prev_en !== 1'b1) begin
      en_rise  = cyc;
      gap_pend = 1'b1;
    end
    if (bus.SS_n === 1'b0 && prev_ss === 1'b1) begin
      ss_falls++;
      rises = 0;
      if (gap_pend) begin
        gap_q.push_back(cyc - en_rise);
        gap_pend = 1'b0;
      end
    end
    if (bus.SCLK === 1'b1 && prev_sclk === 1'b0 && bus.SS_n === 1'b0) begin
      rises++;
      if (rises > 1) begin
        per_n++;
        if (cyc - last_rise != int'(SCLK_DIV)) per_bad++;
      end
      last_rise = cyc;
    end
    if (bus.SS_n === 1'b1 && prev_ss === 1'b0) rise_q.push_back(rises);
    prev_ss   = bus.SS_n;
    prev_sclk = bus.SCLK;
    prev_en   = bus.IR_en;
  end

  // Reference open-flag state
  logic m_lopn = 1'b0, m_ropn = 1'b0;

  function automatic logic opn_ref(input logic cur, input logic [11:0] s);
    int v = int'(s);
    if (v < 'h400) return 1'b1;
    if (v > 'h400 + 'h080) return 1'b0;
    return cur;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_a2d(input logic [11:0] l, input logic [11:0] r, input logic [3:0] top);
    a2d_val[1] = l;
    a2d_val[0] = r;
    a2d_top    = top;
  endtask

  task automatic wait_vld(input int budget, input string tag);
    bit got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (bus.IR_vld === 1'b1) got = 1'b1;
    end
    check({tag, "_vld_seen"}, 32'(got), 32'd1);
  endtask

  task automatic check_scan(input string tag, input logic [11:0] l, input logic [11:0] r);
    m_lopn = opn_ref(m_lopn, l);
    m_ropn = opn_ref(m_ropn, r);
    check({tag, "_lft_IR"},   32'(bus.lft_IR),   32'(l));
    check({tag, "_rght_IR"},  32'(bus.rght_IR),  32'(r));
    check({tag, "_lft_opn"},  32'(bus.lft_opn),  32'(m_lopn));
    check({tag, "_rght_opn"}, 32'(bus.rght_opn), 32'(m_ropn));
  endtask

  task automatic check_mosi(input string tag);
    logic [15:0] exp_w [4];
    exp_w = '{16'h0800, 16'h0800, 16'h0000, 16'h0000};
    check({tag, "_mosi_frames"}, 32'(mosi_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < mosi_log.size(); i++)
      check($sformatf("%s_mosi%0d", tag, i), 32'(mosi_log[i]), 32'(exp_w[i]));
  endtask

  logic [11:0] t3_l [4];
  bit          t3_o [4];
  logic [11:0] l, r;
  int          base, vc, sf, ie, bad, tmo;

  initial begin
    t3_l = '{12'h3F0, 12'h420, 12'h481, 12'h410};
    t3_o = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) a2d_val[i] = 12'h000;

    rst    = 1'b1;
    bus.en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_SS_n",     32'(bus.SS_n),     32'd1);
    check("rst_SCLK",     32'(bus.SCLK),     32'd1);
    check("rst_MOSI",     32'(bus.MOSI),     32'd0);
    check("rst_IR_en",    32'(bus.IR_en),    32'd0);
    check("rst_lft_IR",   32'(bus.lft_IR),   32'd0);
    check("rst_rght_IR",  32'(bus.rght_IR),  32'd0);
    check("rst_opn",      32'({bus.lft_opn, bus.rght_opn}), 32'd0);
    check("rst_IR_vld",   32'(bus.IR_vld),   32'd0);

    // Scan 1: fixed readings, command words, settle time, single pulse
    set_a2d(12'hA5C, 12'h903, 4'($urandom));
    mosi_log.delete();
    rise_q.delete();
    gap_q.delete();
    rst    = 1'b0;
    bus.en = 1'b1;
    wait_vld(SCAN_LEN + 100, "scan1");
    check_scan("scan1", 12'hA5C, 12'h903);
    check("scan1_lft_opn0", 32'(bus.lft_opn), 32'd0);
    check_mosi("scan1");
    check("scan1_settle_gap", 32'(gap_q.size() > 0 ? gap_q[0] : -1), 32'(EN_SETTLE));
    set_a2d(12'h123, 12'($urandom), 4'hF);
    r = a2d_val[0];
    @(negedge clk);
    check("scan1_vld_width", 32'(bus.IR_vld), 32'd0);
    check("scan1_vld_count", 32'(vld_cnt), 32'd1);

    // Scan 2: upper nibble of the A2D word is discarded; frame shape
    wait_vld(SCAN_LEN + 100, "scan2");
    check_scan("scan2", 12'h123, r);
    bad = 0;
    foreach (rise_q[i]) if (rise_q[i] != 16) bad++;
    check("frame_count",       32'(rise_q.size()), 32'd8);
    check("frame_rises_bad",   32'(bad),           32'd0);
    check("sclk_period_count", 32'(per_n),         32'd120);
    check("sclk_period_bad",   32'(per_bad),       32'd0);

    // Left hysteresis sequence, en held throughout
    for (int k = 0; k < 4; k++) begin
      r = 12'($urandom_range(12'h380, 12'h4A0));
      set_a2d(t3_l[k], r, 4'($urandom));
      wait_vld(SCAN_LEN + 100, $sformatf("hyst%0d", k));
      check_scan($sformatf("hyst%0d", k), t3_l[k], r);
      check($sformatf("hyst%0d_lft_opn_table", k), 32'(bus.lft_opn), 32'(t3_o[k]));
    end
    for (int i = 1; i < vld_t.size(); i++)
      check($sformatf("vld_spacing%0d", i), 32'(vld_t[i] - vld_t[i-1]), 32'(SCAN_LEN));

    // Randomized readings, biased around the threshold window
    for (int k = 0; k < 3; k++) begin
      l = (k == 1) ? 12'($urandom) : 12'($urandom_range(12'h3C0, 12'h4C0));
      r = (k == 2) ? 12'($urandom) : 12'($urandom_range(12'h3C0, 12'h4C0));
      set_a2d(l, r, 4'($urandom));
      wait_vld(SCAN_LEN + 100, $sformatf("rand%0d", k));
      check_scan($sformatf("rand%0d", k), l, r);
    end
    set_a2d(12'h777, 12'h111, 4'h0);

    // Reset in the middle of the left data frame
    base = ss_falls;
    tmo  = 0;
    while (ss_falls < base + 2 && tmo < SCAN_LEN + 100) begin
      @(negedge clk);
      tmo++;
    end
    repeat (100) @(negedge clk);
    check("midrst_in_frame", 32'(bus.SS_n), 32'd0);
    rst = 1'b1;
    #1;
    check("midrst_SS_n",    32'(bus.SS_n),    32'd1);
    check("midrst_SCLK",    32'(bus.SCLK),    32'd1);
    check("midrst_IR_en",   32'(bus.IR_en),   32'd0);
    check("midrst_outputs", 32'({bus.MOSI, bus.lft_IR, bus.rght_IR, bus.lft_opn, bus.rght_opn, bus.IR_vld}), 32'd0);
    m_lopn = 1'b0;
    m_ropn = 1'b0;
    repeat (2) @(negedge clk);
    l = 12'($urandom);
    r = 12'($urandom);
    set_a2d(l, r, 4'($urandom));
    mosi_log.delete();
    base = ss_falls;
    vc   = vld_cnt;
    rst  = 1'b0;
    wait_vld(SCAN_LEN + 100, "fresh");
    check_scan("fresh", l, r);
    check("fresh_frames", 32'(ss_falls - base), 32'd4);
    check_mosi("fresh");
    @(negedge clk);
    check("fresh_vld_count", 32'(vld_cnt - vc), 32'd1);

    // Drop en during the right command frame
    l = 12'($urandom);
    r = 12'($urandom);
    set_a2d(l, r, 4'($urandom));
    base = ss_falls;
    vc   = vld_cnt;
    tmo  = 0;
    while (ss_falls < base + 3 && tmo < SCAN_LEN + 100) begin
      @(negedge clk);
      tmo++;
    end
    repeat (10) @(negedge clk);
    bus.en = 1'b0;
    wait_vld(SCAN_LEN, "endrop");
    check_scan("endrop", l, r);
    @(negedge clk);
    sf = ss_falls;
    ie = ir_en_hi;
    check("endrop_frames", 32'(sf - base), 32'd4);
    repeat (2 * SCAN_LEN) @(negedge clk);
    check("endrop_vld_count",  32'(vld_cnt - vc),  32'd1);
    check("endrop_no_frames",  32'(ss_falls - sf), 32'd0);
    check("endrop_no_ir_en",   32'(ir_en_hi - ie), 32'd0);
    check("endrop_SS_n_idle",  32'(bus.SS_n),      32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
